// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter that shares one 64-bit adder/subtractor among NREQ requesters.
// The result, signed-overflow flag and owner ID are returned on a registered valid/ready channel.
module addsub_rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_in1,
  input  logic [NREQ*64-1:0]   req_in2,
  input  logic [NREQ-1:0]      req_m,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_data,
  output logic                 rsp_ovf,
  output logic [ID_W-1:0]      rsp_id,
  output logic [CNT_W-1:0]     op_count
);

  localparam int unsigned DW = 64;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W:0]   scan_pos;
  logic            grant_found;
  logic            accept;
  logic            handshake;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            sel_m;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic            op_m;
  logic [ID_W-1:0] op_id;
  logic [DW-1:0]   b_eff;
  logic [DW-1:0]   sum;
  logic            ovf;

  // Scan from rr_ptr upward; iterating downward leaves the nearest valid requester as the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_pos    = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      scan_pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_pos >= (ID_W+1)'(NREQ)) begin
        scan_pos = scan_pos - (ID_W+1)'(NREQ);
      end
      if (req_valid[scan_pos[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_pos[ID_W-1:0];
      end
    end
  end

  assign next_ptr  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
  assign handshake = (state == RESP) && rsp_ready;
  assign accept    = rst_n && grant_found && ((state == IDLE) || handshake);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_m = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_in1[DW*i +: DW];
        sel_b = req_in2[DW*i +: DW];
        sel_m = req_m[i];
      end
    end
  end

  // Subtraction is in1 + ~in2 + 1; overflow compares signs against the effective operand.
  always_comb begin
    b_eff = op_m ? ~op_b : op_b;
    sum   = op_a + b_eff + DW'(op_m);
    ovf   = (op_a[DW-1] == b_eff[DW-1]) && (sum[DW-1] != op_a[DW-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_m      <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_m   <= sel_m;
        op_id  <= grant_idx;
        rr_ptr <= next_ptr;
      end
      if (handshake) begin
        op_count <= op_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= sum;
          rsp_ovf   <= ovf;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Bench for addsub_rr_arbiter: transaction-level reference model checked every cycle,
// directed literal scenarios, then randomized traffic with occasional resets.
module tb_addsub_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*64-1:0]  req_in1;
  logic [NREQ*64-1:0]  req_in2;
  logic [NREQ-1:0]     req_m;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [63:0]         rsp_data;
  logic                rsp_ovf;
  logic [ID_W-1:0]     rsp_id;
  logic [CNT_W-1:0]    op_count;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_m     (req_m),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // True signed arithmetic in 66 bits; overflow when the exact result leaves the 64-bit range.
  function automatic void calc(input logic [63:0] a, input logic [63:0] b, input bit m,
                               output logic [63:0] r, output bit o);
    logic signed [65:0] sa, sb, s;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    s  = m ? (sa - sb) : (sa + sb);
    r  = s[63:0];
    o  = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
  endfunction

  // Reference model: an operation "in flight", a pending response, a pointer and a count.
  int          m_ptr;
  bit          m_exec, m_rv;
  logic [63:0] m_data;
  bit          m_ovf;
  int          m_id;
  logic [15:0] m_count;
  logic [63:0] t_a, t_b;
  bit          t_m;
  int          t_id;

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] exp_ready;
    logic [63:0]     r;
    bit              o, hs;
    int              g;
    if (!rst_n) begin
      m_ptr = 0; m_exec = 0; m_rv = 0; m_data = '0; m_ovf = 0; m_id = 0; m_count = '0;
    end
    hs = rst_n && m_rv && rsp_ready;
    g  = -1;
    if (rst_n && ((!m_exec && !m_rv) || hs)) begin
      for (int k = 0; k < NREQ; k++) begin
        int p;
        p = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[p]) g = p;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    chk("rsp_data",  rsp_data, m_data);
    chk("rsp_ovf",   64'(rsp_ovf), 64'(m_ovf));
    chk("rsp_id",    64'(rsp_id), 64'(m_id));
    chk("op_count",  64'(op_count), 64'(m_count));
    if (rst_n) begin
      if (hs) begin
        m_count = m_count + 16'd1;
        m_rv    = 0;
      end
      if (m_exec) begin
        calc(t_a, t_b, t_m, r, o);
        m_data = r; m_ovf = o; m_id = t_id; m_rv = 1; m_exec = 0;
      end
      if (g >= 0) begin
        t_a = req_in1[64*g +: 64];
        t_b = req_in2[64*g +: 64];
        t_m = req_m[g];
        t_id = g;
        m_exec = 1;
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input bit m);
    req_in1[64*i +: 64] = a;
    req_in2[64*i +: 64] = b;
    req_m[i] = m;
  endtask

  // Single request with rsp_ready held high: checks accept, latency and literal result.
  task automatic do_op(input int i, input logic [63:0] a, input logic [63:0] b, input bit m,
                       input logic [63:0] e_data, input bit e_ovf, input string name);
    int n;
    bit got;
    set_req(i, a, b, m);
    req_valid[i] = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (req_ready[i]) got = 1;
    end
    chk({name, "_accept"}, 64'(got), 64'd1);
    tick();
    req_valid[i] = 1'b0;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (rsp_valid) got = 1;
    end
    chk({name, "_latency"}, 64'(n), 64'd2);
    chk({name, "_data"}, rsp_data, e_data);
    chk({name, "_ovf"}, 64'(rsp_ovf), 64'(e_ovf));
    chk({name, "_id"}, 64'(rsp_id), 64'(i));
    tick();
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stim
    int n, hsn;
    logic [ID_W-1:0] ids [6];
    rst_n = 1'b0; req_valid = '0; req_in1 = '0; req_in2 = '0; req_m = '0; rsp_ready = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();

    do_op(0, 64'd11, 64'd3, 1'b0, 64'd14, 1'b0, "t1");
    do_op(2, 64'd64, 64'd64, 1'b1, 64'd0, 1'b0, "t2a");
    do_op(2, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "t2b");
    do_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, "t3a");
    do_op(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "t3b");

    // T4: fairness under full load after a fresh reset.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, pick(), pick(), 1'($urandom));
    req_valid = '1;
    n = 0; hsn = 0;
    while (hsn < 6 && n < 100) begin
      @(negedge clk); n++;
      if (rsp_valid && rsp_ready) begin
        ids[hsn] = rsp_id;
        hsn++;
      end
    end
    chk("t4_handshakes", 64'(hsn), 64'd6);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t4_op_count", 64'(op_count), 64'd6);
    for (int j = 0; j < 6; j++) chk("t4_id_seq", 64'(ids[j]), 64'(j % NREQ));
    repeat (4) tick();

    // T5: back-pressure holds the response and blocks new accepts.
    rsp_ready = 1'b0;
    set_req(3, 64'd100, 64'd1, 1'b1);
    set_req(1, 64'd2, 64'd3, 1'b0);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_grant3", 64'(req_ready), 64'b1000);
    tick();
    req_valid[3] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    chk("t5_valid", 64'(rsp_valid), 64'd1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t5_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t5_hold_data", rsp_data, 64'd99);
      chk("t5_hold_id", 64'(rsp_id), 64'd3);
      chk("t5_hold_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_release_grant1", 64'(req_ready), 64'b0010);
    chk("t5_count_before", 64'(op_count), 64'd7);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_count_after", 64'(op_count), 64'd8);
    repeat (4) tick();

    // T6: reset while an operation is executing.
    set_req(2, 64'd40, 64'd2, 1'b0);
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("t6_grant2", 64'(req_ready), 64'b0100);
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("t6_rst_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rst_data", rsp_data, 64'd0);
    chk("t6_rst_ovf", 64'(rsp_ovf), 64'd0);
    chk("t6_rst_id", 64'(rsp_id), 64'd0);
    chk("t6_rst_count", 64'(op_count), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("t6_ptr_restart", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Randomized traffic; occasional single-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_req(i, pick(), pick(), 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
